// File: rtl/instr_mem_multiport.sv
// Multi-port instruction memory: NUM_PORTS concurrent 1-cycle reads in RUN, handshaked loading in LOAD.
// Optional even-parity protection per word is enabled with the INSTR_MEM_PARITY_EN macro.
module instr_mem_multiport #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
  output logic [NUM_PORTS-1:0]          rd_valid,
  output logic [NUM_PORTS-1:0]          rd_err,
`ifdef INSTR_MEM_PARITY_EN
  output logic [NUM_PORTS-1:0]          rd_perr,
`endif
  input  logic                          prog_start,
  input  logic                          prog_done,
  input  logic                          ld_valid,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          ld_ready,
  output logic [ADDR_W:0]               ld_count,
  output logic                          ld_err,
  output logic                          busy
);

  // Handshake: a load word is written on a rising edge where ld_valid and ld_ready are both 1;
  // ld_ready is high for the whole LOAD state and ld_valid may be held or dropped freely.

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_RUN, ST_LOAD} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W:0]               ld_count_q, ld_count_d;
  logic                          ld_err_q, ld_err_d;
  logic [NUM_PORTS*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_PORTS-1:0]          rd_valid_q, rd_valid_d;
  logic [NUM_PORTS-1:0]          rd_err_q, rd_err_d;
`ifdef INSTR_MEM_PARITY_EN
  logic [NUM_PORTS-1:0]          rd_perr_q, rd_perr_d;
`endif

  logic [MEM_W-1:0]              mem [DEPTH];
  logic                          ld_in_range;
  logic                          wr_en;
  logic [MEM_W-1:0]              wr_word;
  logic [MEM_W-1:0]              rd_word;
  logic                          rd_in_range;

  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_L);
  assign wr_en       = (state_q == ST_LOAD) && ld_valid && ld_in_range;
`ifdef INSTR_MEM_PARITY_EN
  assign wr_word     = {^ld_data, ld_data};
`else
  assign wr_word     = ld_data;
`endif

  // Storage has no reset so a reset in the middle of a load keeps the words already written.
  always_ff @(posedge clock) begin
    if (wr_en) mem[ld_addr[IDX_W-1:0]] <= wr_word;
  end

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    unique case (state_q)
      ST_RUN: begin
        if (prog_start) begin
          state_d    = ST_LOAD;
          ld_count_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (!ld_in_range)              ld_err_d   = 1'b1;
          else if (ld_count_q != DEPTH_L) ld_count_d = ld_count_q + (ADDR_W+1)'(1);
        end
        // prog_done beats prog_start; a restart clears the session counters even over a same-edge write.
        if (prog_done) begin
          state_d = ST_RUN;
        end else if (prog_start) begin
          ld_count_d = '0;
          ld_err_d   = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    rd_data_d   = rd_data_q;
    rd_valid_d  = '0;
    rd_err_d    = '0;
    rd_word     = '0;
    rd_in_range = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
    rd_perr_d   = '0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word     = mem[rd_addr[p*ADDR_W +: IDX_W]];
      rd_in_range = ({1'b0, rd_addr[p*ADDR_W +: ADDR_W]} < DEPTH_L);
      if ((state_q == ST_RUN) && rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        rd_err_d[p]   = !rd_in_range;
        rd_data_d[p*DATA_W +: DATA_W] = rd_in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef INSTR_MEM_PARITY_EN
        // Stored word includes its parity bit, so an intact word always reduces to 0.
        rd_perr_d[p]  = rd_in_range && (^rd_word);
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_err_q   <= '0;
`ifdef INSTR_MEM_PARITY_EN
      rd_perr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
`ifdef INSTR_MEM_PARITY_EN
      rd_perr_q  <= rd_perr_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
`ifdef INSTR_MEM_PARITY_EN
  assign rd_perr  = rd_perr_q;
`endif
  assign ld_count = ld_count_q;
  assign ld_err   = ld_err_q;
  assign busy     = (state_q == ST_LOAD);
  assign ld_ready = (state_q == ST_LOAD);

endmodule

// File: tb/tb_instr_mem_multiport.sv
// Bench for instr_mem_multiport: directed load/read tables, corner sequences and randomized traffic
// checked against an array-based reference model. Parity checks compile in with INSTR_MEM_PARITY_EN.
module tb_instr_mem_multiport;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 256;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_valid;
  logic [NP-1:0]     rd_err;
`ifdef INSTR_MEM_PARITY_EN
  logic [NP-1:0]     rd_perr;
`endif
  logic              prog_start;
  logic              prog_done;
  logic              ld_valid;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;
  logic              ld_ready;
  logic [AW:0]       ld_count;
  logic              ld_err;
  logic              busy;

  instr_mem_multiport #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
`ifdef INSTR_MEM_PARITY_EN
    .rd_perr(rd_perr),
`endif
    .prog_start(prog_start), .prog_done(prog_done),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_count(ld_count), .ld_err(ld_err), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_written [DEPTH];
  bit            m_corrupt [DEPTH];
  bit            m_load;
  int            m_count;
  bit            m_lerr;
  logic [DW-1:0] m_rd_data [NP];
  logic [NP-1:0] m_valid, m_rerr, m_perr;

  typedef struct packed {
    logic [NP-1:0]    en;
    logic [NP*AW-1:0] addr;
    logic [NP-1:0]    exp_valid;
    logic [NP-1:0]    exp_err;
    logic [NP*DW-1:0] exp_data;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 1'b0; m_count = 0; m_lerr = 1'b0;
    m_valid = '0; m_rerr = '0; m_perr = '0;
    for (int p = 0; p < NP; p++) m_rd_data[p] = '0;
  endtask

  // Applies the inputs present at this rising edge to the model.
  task automatic model_edge();
    int a;
    for (int p = 0; p < NP; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      if (!m_load && rd_en[p]) begin
        m_valid[p] = 1'b1;
        if (a >= DEPTH) begin
          m_rerr[p] = 1'b1; m_rd_data[p] = '0; m_perr[p] = 1'b0;
        end else begin
          m_rerr[p] = 1'b0; m_rd_data[p] = m_mem[a]; m_perr[p] = m_corrupt[a];
        end
      end else begin
        m_valid[p] = 1'b0; m_rerr[p] = 1'b0; m_perr[p] = 1'b0;
      end
    end
    if (m_load && ld_valid) begin
      a = int'(ld_addr);
      if (a < DEPTH) begin
        m_mem[a] = ld_data; m_written[a] = 1'b1; m_corrupt[a] = 1'b0;
        if (m_count < DEPTH) m_count++;
      end else begin
        m_lerr = 1'b1;
      end
    end
    if (!m_load) begin
      if (prog_start) begin m_load = 1'b1; m_count = 0; m_lerr = 1'b0; end
    end else if (prog_done) begin
      m_load = 1'b0;
    end else if (prog_start) begin
      m_count = 0; m_lerr = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NP*DW-1:0] e;
    for (int p = 0; p < NP; p++) e[p*DW +: DW] = m_rd_data[p];
    check({tag, " rd_valid"}, 64'(rd_valid), 64'(m_valid));
    check({tag, " rd_err"},   64'(rd_err),   64'(m_rerr));
    check({tag, " rd_data"},  64'(rd_data),  64'(e));
    check({tag, " ld_count"}, 64'(ld_count), 64'(m_count));
    check({tag, " ld_err"},   64'(ld_err),   64'(m_lerr));
    check({tag, " busy"},     64'(busy),     64'(m_load));
    check({tag, " ld_ready"}, 64'(ld_ready), 64'(m_load));
`ifdef INSTR_MEM_PARITY_EN
    check({tag, " rd_perr"},  64'(rd_perr),  64'(m_perr));
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    step("load");
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    prog_start = 1'b1; step("prog_start"); prog_start = 1'b0;
  endtask

  task automatic pulse_done();
    prog_done = 1'b1; step("prog_done"); prog_done = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    reset_n = 1'b0; rd_en = '0; rd_addr = '0; prog_start = 1'b0; prog_done = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin m_written[i] = 1'b0; m_corrupt[i] = 1'b0; m_mem[i] = '0; end
    model_reset();

    vecs[0] = '{4'b1111, {16'd9, 16'd8, 16'd5, 16'd1}, 4'b1111, 4'b0000,
                {16'h9999, 16'h0808, 16'h5555, 16'h1234}};
    vecs[1] = '{4'b1111, {16'd300, 16'd82, 16'd81, 16'd80}, 4'b1111, 4'b1000,
                {16'h0000, 16'h8282, 16'h8181, 16'h8080}};
    vecs[2] = '{4'b0101, {16'd9, 16'd9, 16'd9, 16'd9}, 4'b0101, 4'b0000,
                {16'h0000, 16'h9999, 16'h8181, 16'h9999}};
    vecs[3] = '{4'b0000, {16'd5, 16'd5, 16'd5, 16'd5}, 4'b0000, 4'b0000,
                {16'h0000, 16'h9999, 16'h8181, 16'h9999}};
    vecs[4] = '{4'b1111, {16'd5, 16'd5, 16'd5, 16'd5}, 4'b1111, 4'b0000,
                {16'h5555, 16'h5555, 16'h5555, 16'h5555}};
    vecs[5] = '{4'b1111, {16'd1, 16'hFFFF, 16'd256, 16'd255}, 4'b1111, 4'b0110,
                {16'h1234, 16'h0000, 16'h0000, 16'h00FF}};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset");
    @(negedge clock) reset_n = 1'b1;

    // First load session
    pulse_start();
    check("load busy high", 64'(busy), 64'd1);
    load_word(16'd1, 16'h1234);
    load_word(16'd5, 16'h5555);
    load_word(16'd8, 16'h0808);
    load_word(16'd9, 16'h9999);
    pulse_done();
    check("load1 ld_count", 64'(ld_count), 64'd4);
    check("load1 ld_err", 64'(ld_err), 64'd0);
    check("load1 busy low", 64'(busy), 64'd0);

    // Second session, including boundary and out-of-range loads
    pulse_start();
    load_word(16'd80, 16'h8080);
    load_word(16'd81, 16'h8181);
    load_word(16'd82, 16'h8282);
    load_word(16'd255, 16'h00FF);
    load_word(16'd300, 16'hDEAD);
    check("load2 ld_err after 300", 64'(ld_err), 64'd1);
    check("load2 ld_count after 300", 64'(ld_count), 64'd4);
    load_word(16'd256, 16'hBEEF);
    check("load2 ld_count after 256", 64'(ld_count), 64'd4);
    pulse_done();

    // Table-driven reads
    for (int i = 0; i < 6; i++) begin
      rd_en = vecs[i].en; rd_addr = vecs[i].addr;
      step("vec");
      check($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d rd_err", i),   64'(rd_err),   64'(vecs[i].exp_err));
      check($sformatf("vec%0d rd_data", i),  64'(rd_data),  64'(vecs[i].exp_data));
    end
    rd_en = '0;
    step("idle");

    // Reads around the RUN/LOAD transitions
    rd_en = 4'b1111; rd_addr = {16'd9, 16'd8, 16'd5, 16'd1};
    prog_start = 1'b1;
    step("read at start edge");
    prog_start = 1'b0;
    check("start edge read valid", 64'(rd_valid), 64'hF);
    check("start edge read data", 64'(rd_data), 64'h9999_0808_5555_1234);
    rd_addr = {16'd82, 16'd81, 16'd80, 16'd255};
    step("read in load");
    check("load read valid", 64'(rd_valid), 64'h0);
    check("load read data held", 64'(rd_data), 64'h9999_0808_5555_1234);
    prog_done = 1'b1;
    step("read at done edge");
    prog_done = 1'b0;
    check("done edge read refused", 64'(rd_valid), 64'h0);
    step("read after done");
    check("post done read data", 64'(rd_data), 64'h8282_8181_8080_00FF);
    rd_en = '0;

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(256, 65535));
        else begin
          ra = 16'($urandom_range(0, 31));
          if (!m_written[ra]) ra = 16'd1;
        end
        rd_addr[p*AW +: AW] = ra;
      end
      rd_en = 4'($urandom);
      prog_start = m_load ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 14) == 0);
      prog_done  = m_load ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) == 0);
      ld_valid   = 1'($urandom);
      ld_addr    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(250, 265)) : 16'($urandom_range(0, 31));
      ld_data    = 16'($urandom);
      step("random");
    end
    rd_en = '0; prog_start = 1'b0; ld_valid = 1'b0;
    if (m_load) pulse_done();
    prog_done = 1'b0;

    // Reset in the middle of a load session
    pulse_start();
    load_word(16'd1, 16'hABCD);
    load_word(16'd2, 16'h2222);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid-load reset");
    check("reset ld_count", 64'(ld_count), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    @(negedge clock) reset_n = 1'b1;
    rd_en = 4'b0001; rd_addr = {16'd0, 16'd0, 16'd0, 16'd1};
    step("read after reset");
    check("retained addr1 data", 64'(rd_data[15:0]), 64'hABCD);
    check("retained addr1 valid", 64'(rd_valid[0]), 64'd1);
    rd_en = '0;

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt one stored data bit of addr 5 behind the parity bit's back
    pulse_start();
    load_word(16'd5, 16'h5555);
    pulse_done();
    dut.mem[5][0] = ~dut.mem[5][0];
    m_mem[5][0] = ~m_mem[5][0];
    m_corrupt[5] = 1'b1;
    rd_en = 4'b0101; rd_addr = {16'd0, 16'd5, 16'd0, 16'd1};
    step("parity read");
    check("parity rd_perr[2]", 64'(rd_perr[2]), 64'd1);
    check("parity rd_valid[2]", 64'(rd_valid[2]), 64'd1);
    check("parity clean port0", 64'(rd_perr[0]), 64'd0);
    rd_en = '0;
    step("parity idle");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_multiport.md
INSTR_MEM_MULTIPORT -- requirements
Module: instr_mem_multiport

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, setting the number of independent core read ports.
REQ-002 The block SHALL have parameter DATA_W, default 16, setting the instruction word width.
REQ-003 The block SHALL have parameter ADDR_W, default 16, setting the address width.
REQ-004 The block SHALL have parameter DEPTH, default 256, setting the number of words (DEPTH <= 2^ADDR_W).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port rd_en, input, NUM_PORTS bits: per-port read request.
REQ-008 The block SHALL have port rd_addr, input, NUM_PORTS*ADDR_W bits: per-port address, with port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port rd_data, output, NUM_PORTS*DATA_W bits: per-port instruction, packed the same way as rd_addr.
REQ-010 The block SHALL have port rd_valid, output, NUM_PORTS bits: per-port data valid.
REQ-011 The block SHALL have port rd_err, output, NUM_PORTS bits: per-port out-of-range address flag.
REQ-012 The block SHALL have port prog_start, input, 1 bit: pulse that enters LOAD state.
REQ-013 The block SHALL have port prog_done, input, 1 bit: pulse that returns to RUN state.
REQ-014 The block SHALL have ports ld_valid, input, 1 bit; ld_addr, input, ADDR_W bits; ld_data, input, DATA_W bits; and ld_ready, output, 1 bit; together these form the load write handshake.
REQ-015 The block SHALL have port ld_count, output, ADDR_W+1 bits: number of words accepted in the current load session.
REQ-016 The block SHALL have port ld_err, output, 1 bit: sticky flag meaning an out-of-range load was dropped.
REQ-017 The block SHALL have port busy, output, 1 bit: high while in LOAD state.

Function
REQ-018 The block SHALL implement a two-state FSM, RUN and LOAD, with reset state RUN.
REQ-019 In RUN, prog_start=1 SHALL move the FSM to LOAD on the next edge; prog_done SHALL be ignored.
REQ-020 In LOAD, prog_done=1 SHALL move the FSM to RUN on the next edge; prog_start=1 in LOAD SHALL clear ld_count and ld_err and keep the FSM in LOAD.
REQ-021 If prog_start and prog_done are both 1 in one cycle, prog_done SHALL win in LOAD and prog_start SHALL win in RUN.
REQ-022 ld_ready SHALL be 1 exactly when the FSM is in LOAD; a write SHALL occur on an edge where ld_valid and ld_ready are both 1.
REQ-023 A write with ld_addr < DEPTH SHALL store ld_data and increment ld_count, which saturates at DEPTH.
REQ-024 A write with ld_addr >= DEPTH SHALL be dropped, SHALL set ld_err, and SHALL leave ld_count unchanged.
REQ-025 On entry to LOAD from RUN, ld_count and ld_err SHALL clear to 0.
REQ-026 In RUN, rd_en[p]=1 at edge N SHALL give rd_valid[p]=1 and rd_data[p]=mem[rd_addr[p]] after edge N, a 1-cycle latency.
REQ-027 All ports SHALL read concurrently with no arbitration; identical addresses on several ports SHALL each return the same word.
REQ-028 A read with rd_addr[p] >= DEPTH SHALL give rd_valid[p]=1, rd_err[p]=1 and rd_data[p]=0.
REQ-029 rd_en[p]=0 SHALL give rd_valid[p]=0 and rd_err[p]=0 on the next cycle, with rd_data[p] holding its last value.
REQ-030 In LOAD, all reads SHALL be refused: rd_valid=0, rd_err=0, rd_data held.
REQ-031 A read on the same edge as the RUN->LOAD transition SHALL be served; a read on the same edge as the LOAD->RUN transition SHALL be refused.
REQ-032 busy SHALL equal (state==LOAD), registered.

Reset
REQ-033 On reset_n=0, the block SHALL set, asynchronously: state=RUN, rd_data=0, rd_valid=0, rd_err=0, ld_count=0, ld_err=0, busy=0, ld_ready=0.
REQ-034 Memory contents SHALL NOT be cleared by reset; reset during LOAD SHALL abort the session, and words already written SHALL be retained.

Configuration
REQ-035 With macro INSTR_MEM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed at load time, and the block SHALL add output rd_perr[NUM_PORTS], asserted with rd_valid when the recomputed parity mismatches (reset value 0).
REQ-036 With INSTR_MEM_PARITY_EN undefined, the block SHALL have no parity storage and no rd_perr port.

Verification
REQ-037 The bench SHALL cover load: prog_start; write addr 1=0x1234, 5=0x5555, 8=0x0808, 9=0x9999; prog_done -> ld_count=4, ld_err=0, busy high then low.
REQ-038 The bench SHALL cover quad read: RUN, rd_en=4'b1111, addrs 1/5/8/9 -> one cycle later rd_valid=4'b1111 and data 0x1234/0x5555/0x0808/0x9999.
REQ-039 The bench SHALL cover out of range: read addrs 80/81/82/300 with DEPTH=256 -> port 3 rd_err=1, rd_data=0; ports 0-2 data valid; also a load to addr 300 -> ld_err=1, ld_count unchanged.
REQ-040 The bench SHALL cover a read in LOAD: rd_en=4'b1111 while busy -> rd_valid=0 on all ports, rd_data unchanged.
REQ-041 The bench SHALL cover reset mid-load: after 2 writes assert reset_n=0 -> state RUN, ld_count=0, and a read of addr 1 returns the value just written.
REQ-042 The bench SHALL cover parity (with INSTR_MEM_PARITY_EN): force-flip a stored bit of addr 5, then read -> rd_perr[port]=1 with rd_valid=1.
